// File: rtl/aes_pkg.sv
// Shared Rijndael constants and helpers for the ShiftRows datapath.
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int ROWS   = 4;

    // Block widths supported by the Rijndael ShiftRows offset table.
    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Supported register depths of the stage pipeline.
    function automatic bit pipe_legal(input int pipe);
        return (pipe >= 1) && (pipe <= 3);
    endfunction

    // Left-rotate amount, in bytes, applied to a row in forward mode.
    function automatic int row_offset(input int nb, input int row);
        int off;
        case (row)
            0:       off = 0;
            1:       off = 1;
            2:       off = (nb == 8) ? 3 : 2;
            default: off = (nb == 8) ? 4 : 3;
        endcase
        return off;
    endfunction

    // Input column that feeds output column col of a row.
    function automatic int src_col(input int nb, input int row, input int col, input bit inv);
        int off;
        off = row_offset(nb, row);
        if (inv) begin
            return (col - off + nb) % nb;
        end
        return (col + off) % nb;
    endfunction

endpackage

// File: rtl/shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Every output byte is a 2:1 mux between its forward and inverse source byte;
// all source positions are elaboration-time constants.
module shiftrows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [ROWS*BYTE_W*NB-1:0] data,
    input  logic                      inv,
    output logic [ROWS*BYTE_W*NB-1:0] result
);

    localparam int ROW_W = BYTE_W * NB;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            // Column c sits at the high end of the row, so column 0 is the MSB byte.
            localparam int DST_LSB = r * ROW_W + BYTE_W * (NB - 1 - c);
            localparam int FWD_LSB = r * ROW_W + BYTE_W * (NB - 1 - src_col(NB, r, c, 1'b0));
            localparam int INV_LSB = r * ROW_W + BYTE_W * (NB - 1 - src_col(NB, r, c, 1'b1));

            assign result[DST_LSB +: BYTE_W] = inv ? data[INV_LSB +: BYTE_W]
                                                   : data[FWD_LSB +: BYTE_W];
        end
    end

endmodule

// File: rtl/shiftrows_pipe.sv
// ShiftRows / InvShiftRows with a PIPE-deep valid/ready register pipeline.
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both high; a producer keeps valid and its payload steady until that
// edge. Each stage loads when the stage after it is empty or is itself loading
// this cycle, so a full pipe with out_ready high moves every beat forward in one
// edge and in_ready may depend combinationally on out_ready.
module shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int PIPE  = 2,
    parameter int TAG_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_inv,
    input  logic [ROWS*BYTE_W*NB-1:0] in_data,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROWS*BYTE_W*NB-1:0] out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      busy
);

    localparam int DW = ROWS * BYTE_W * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $fatal(1, "shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (!pipe_legal(PIPE)) begin : g_bad_pipe
        $fatal(1, "shiftrows_pipe: PIPE must be 1, 2 or 3");
    end

    logic [DW-1:0]    perm_data;
    logic [PIPE-1:0]  stage_valid;
    logic [PIPE-1:0]  stage_load;
    logic [DW-1:0]    stage_data [PIPE];
    logic [TAG_W-1:0] stage_tag  [PIPE];

    // Index k of a chain is whatever feeds stage k: the permuted input for
    // stage 0, otherwise the stage just before it.
    logic [PIPE:0]    valid_chain;
    logic [DW-1:0]    data_chain [PIPE+1];
    logic [TAG_W-1:0] tag_chain  [PIPE+1];
    logic             room;

    // The permutation sits in front of stage 1; later stages only re-register.
    shiftrows_perm #(
        .NB(NB)
    ) u_perm (
        .data  (in_data),
        .inv   (in_inv),
        .result(perm_data)
    );

    assign valid_chain = {stage_valid, in_valid};

    // Build the per-stage source buses from the permuted input and stage outputs.
    always_comb begin
        data_chain[0] = perm_data;
        tag_chain[0]  = in_tag;
        for (int k = 0; k < PIPE; k++) begin
            data_chain[k+1] = stage_data[k];
            tag_chain[k+1]  = stage_tag[k];
        end
    end

    // Load enables, walked from the output back: a stage may load when any
    // stage after it has a free slot or the output is being drained.
    always_comb begin
        stage_load             = '0;
        room                   = out_ready || !stage_valid[PIPE-1];
        stage_load[PIPE-1]     = room;
        for (int k = PIPE - 2; k >= 0; k--) begin
            room          = room || !stage_valid[k+1];
            stage_load[k] = room;
        end
    end

    // Stage occupancy; reset empties every stage at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (stage_load[k]) begin
                    stage_valid[k] <= valid_chain[k];
                end
            end
        end
    end

    // Payload registers; only written when a real beat arrives, so a stalled
    // output stage keeps its data and tag untouched.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PIPE; k++) begin
            if (stage_load[k] && valid_chain[k]) begin
                stage_data[k] <= data_chain[k];
                stage_tag[k]  <= tag_chain[k];
            end
        end
    end

    assign in_ready  = stage_load[0];
    assign out_valid = stage_valid[PIPE-1];
    assign out_data  = stage_data[PIPE-1];
    assign out_tag   = stage_tag[PIPE-1];
    assign busy      = |stage_valid;

endmodule

// File: doc/shiftrows_pipe.md
SHIFTROWS_PIPE -- requirements
Module: shiftrows_pipe

Interface
REQ-001 Parameter NB, default 4: Rijndael block columns; legal values 4, 6, 8.
REQ-002 Parameter PIPE, default 2: register stages; legal values 1, 2, 3.
REQ-003 Parameter TAG_W, default 8: sideband tag width, carried unchanged with its data.
REQ-004 clk  in  1  the one clock; all state is updated on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 in_valid  in  1  input beat offered.
REQ-007 in_ready  out  1  input beat accepted when in_valid and in_ready are high on the same edge.
REQ-008 in_inv  in  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with the beat.
REQ-009 in_data  in  32*NB  state; row r occupies bits [r*8*NB +: 8*NB]; column c of a row occupies row bits [8*(NB-1-c) +: 8].
REQ-010 in_tag  in  TAG_W  sideband, e.g. CTR block index.
REQ-011 out_valid  out  1  output beat present.
REQ-012 out_ready  in  1  downstream accepts the output beat.
REQ-013 out_data  out  32*NB  permuted state, same layout as in_data.
REQ-014 out_tag  out  TAG_W  tag of the beat on out_data.
REQ-015 busy  out  1  high while any stage holds a valid beat.

Function
REQ-016 Row r shift offsets SHALL be {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-017 Forward mode: output column c of row r = input column (c+off_r) mod NB, i.e. rotate the row left by off_r bytes.
REQ-018 Inverse mode: output column c of row r = input column (c-off_r) mod NB.
REQ-019 The permutation is applied combinationally before stage 1; stages 2..PIPE only register the result.
REQ-020 Each stage holds valid, data and tag; stage k loads when stage k+1 is empty or stage k+1 transfers that cycle (last stage: when out_valid is low or out_ready is high).
REQ-021 in_ready = stage-1 load condition; a combinational path from out_ready to in_ready is permitted.
REQ-022 Latency from accept to out_valid SHALL be exactly PIPE cycles with no back-pressure; throughput is one beat per cycle with out_ready held high.
REQ-023 While out_valid is high and out_ready is low, out_data and out_tag SHALL hold stable, and no beat is dropped or duplicated.
REQ-024 Beats SHALL leave in acceptance order; a mode change between consecutive beats applies per beat with no bubble.
REQ-025 Simultaneous accept and output transfer at full occupancy SHALL be sustained without a stall cycle.
REQ-026 Illegal NB or PIPE values SHALL be caught at elaboration (fatal), not at run time.

Reset
REQ-027 On rst high, all stage valid bits clear immediately: out_valid=0 and busy=0; in_ready=1 once rst is deasserted.
REQ-028 Data and tag registers need no reset; out_data and out_tag are don't-care while out_valid=0.
REQ-029 Reset asserted mid-stream discards all in-flight beats; the first beat after release sees latency PIPE.

Structure
REQ-030 A shared package (aes_pkg) holds the byte width constant, the legal-NB check function and the function returning off_r for a given NB and row.
REQ-031 One sub-module, shiftrows_perm (combinational, parameter NB, inputs data and inv), holds the permutation; shiftrows_pipe instantiates it once and adds the stage pipeline.

Verification
REQ-032 NB=4, PIPE=2, inv=0, in_data=128'h00010203_04050607_08090a0b_0c0d0e0f, tag=8'h5A -> two cycles later out_data=128'h03000102_06070405_090a0b08_0c0d0e0f, out_tag=8'h5A.
REQ-033 Same output fed back with inv=1 -> out_data=128'h00010203_04050607_08090a0b_0c0d0e0f; 1000 random beats with alternating inv give forward-then-inverse identity.
REQ-034 NB=8, row2=bytes 00..07 (col0=00), inv=0 -> row2 out = 03 04 05 06 07 00 01 02; row3 out = 04 05 06 07 00 01 02 03.
REQ-035 PIPE=3, stream tags 0..15 back-to-back, out_ready random at 50% -> tags 0..15 emerge in order, none dropped; data stable on every stalled cycle.
REQ-036 Fill pipe with out_ready=0, pulse rst for 1 cycle -> out_valid=0 and busy=0 asynchronously; next beat appears exactly PIPE cycles after accept.
